// File: rtl/br_resolve_if.sv
// ---------------------------------------------------------------------------
// br_resolve_if
// Bundles every non-clock signal of the branch resolution unit.
//   master : front end / execute side (drives push_*, ex_*, flush)
//   slave  : br_resolve (drives full, upd_*, redirect*, err, n_br, n_mis)
// Signal groups:
//   push side    : push, push_taken, push_index, push_pc, push_target, full
//   execute side : ex_valid, ex_taken, ex_target, flush
//   training     : upd_br, upd_taken, upd_correct, upd_target, upd_index
//   redirect     : redirect, redirect_pc
//   status       : err, n_br, n_mis
// ---------------------------------------------------------------------------
interface br_resolve_if #(
  parameter int IDX_W = 2,
  parameter int CNT_W = 16
);
  logic             push;
  logic             push_taken;
  logic [IDX_W-1:0] push_index;
  logic [31:0]      push_pc;
  logic [31:0]      push_target;
  logic             full;
  logic             ex_valid;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             flush;
  logic             upd_br;
  logic             upd_taken;
  logic             upd_correct;
  logic [31:0]      upd_target;
  logic [IDX_W-1:0] upd_index;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             err;
  logic [CNT_W-1:0] n_br;
  logic [CNT_W-1:0] n_mis;

  modport master (
    output push, push_taken, push_index, push_pc, push_target,
    output ex_valid, ex_taken, ex_target, flush,
    input  full, upd_br, upd_taken, upd_correct, upd_target, upd_index,
    input  redirect, redirect_pc, err, n_br, n_mis
  );

  modport slave (
    input  push, push_taken, push_index, push_pc, push_target,
    input  ex_valid, ex_taken, ex_target, flush,
    output full, upd_br, upd_taken, upd_correct, upd_target, upd_index,
    output redirect, redirect_pc, err, n_br, n_mis
  );
endinterface

// File: rtl/br_resolve.sv
// ---------------------------------------------------------------------------
// br_resolve
// Branch resolution unit. Holds an in-order FIFO of fetch-time predictions,
// pops the oldest one when execute resolves a branch, and produces:
//   - a registered one-cycle training packet (upd_*) for the predictor/BTB,
//   - a registered one-cycle fetch redirect on a mispredict,
//   - saturating resolved-branch / mispredict counters and a sticky err.
// Ports:
//   CLK : clock, all state updates on posedge
//   RST : asynchronous active-high reset
//   bus : br_resolve_if.slave (push, execute, training, redirect, status)
// ---------------------------------------------------------------------------
module br_resolve #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  br_resolve_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] STAT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  // Queue state
  logic [CW-1:0]    count_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic             taken_r  [DEPTH];
  logic [IDX_W-1:0] index_r  [DEPTH];
  logic [31:0]      pc_r     [DEPTH];
  logic [31:0]      target_r [DEPTH];

  // Output registers
  logic             upd_br_r;
  logic             upd_taken_r;
  logic             upd_correct_r;
  logic [31:0]      upd_target_r;
  logic [IDX_W-1:0] upd_index_r;
  logic             redirect_r;
  logic [31:0]      redirect_pc_r;
  logic             err_r;
  logic [CNT_W-1:0] n_br_r;
  logic [CNT_W-1:0] n_mis_r;

  // Combinational decode
  logic        full_s;
  logic        resolve_s;
  logic        correct_s;
  logic        mispredict_s;
  logic        push_ok_s;
  logic        err_set_s;
  logic [31:0] fix_pc_s;
  logic [31:0] train_target_s;

  // Resolution / push acceptance decode for the current cycle
  always_comb begin
    full_s         = (count_r == CNT_FULL);
    resolve_s      = bus.ex_valid && (count_r != CNT_ZERO) && !bus.flush;
    correct_s      = (bus.ex_taken == taken_r[head_r]) &&
                     (!bus.ex_taken || (bus.ex_target == target_r[head_r]));
    mispredict_s   = resolve_s && !correct_s;
    // Pushes shadowed by a flush or an outstanding/new redirect are wrong-path.
    push_ok_s      = bus.push && !full_s && !bus.flush && !mispredict_s && !redirect_r;
    err_set_s      = (bus.push && full_s && !bus.flush && !mispredict_s && !redirect_r) ||
                     (bus.ex_valid && (count_r == CNT_ZERO) && !bus.flush);
    // Not-taken keeps the BTB entry unchanged by writing back the stored target.
    train_target_s = bus.ex_taken ? bus.ex_target : target_r[head_r];
    fix_pc_s       = bus.ex_taken ? bus.ex_target : (pc_r[head_r] + 32'd4);
  end

  // Queue pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_r <= CNT_ZERO;
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
    end else if (bus.flush || mispredict_s) begin
      count_r <= CNT_ZERO;
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
    end else begin
      if (push_ok_s) begin
        tail_r <= tail_r + PTR_ONE;
      end else begin
        tail_r <= tail_r;
      end
      if (resolve_s) begin
        head_r <= head_r + PTR_ONE;
      end else begin
        head_r <= head_r;
      end
      case ({push_ok_s, resolve_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Prediction record storage, written at the tail on an accepted push
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        taken_r[i]  <= 1'b0;
        index_r[i]  <= {IDX_W{1'b0}};
        pc_r[i]     <= 32'd0;
        target_r[i] <= 32'd0;
      end
    end else if (push_ok_s) begin
      taken_r[tail_r]  <= bus.push_taken;
      index_r[tail_r]  <= bus.push_index;
      pc_r[tail_r]     <= bus.push_pc;
      target_r[tail_r] <= bus.push_target;
    end else begin
      taken_r[tail_r]  <= taken_r[tail_r];
    end
  end

  // Training packet and fetch redirect, one cycle after resolution
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      upd_br_r      <= 1'b0;
      upd_taken_r   <= 1'b0;
      upd_correct_r <= 1'b0;
      upd_target_r  <= 32'd0;
      upd_index_r   <= {IDX_W{1'b0}};
      redirect_r    <= 1'b0;
      redirect_pc_r <= 32'd0;
    end else begin
      upd_br_r   <= resolve_s;
      redirect_r <= mispredict_s;
      if (resolve_s) begin
        upd_taken_r   <= bus.ex_taken;
        upd_correct_r <= correct_s;
        upd_target_r  <= train_target_s;
        upd_index_r   <= index_r[head_r];
      end else begin
        upd_taken_r   <= 1'b0;
        upd_correct_r <= 1'b0;
        upd_target_r  <= 32'd0;
        upd_index_r   <= {IDX_W{1'b0}};
      end
      if (mispredict_s) begin
        redirect_pc_r <= fix_pc_s;
      end else begin
        redirect_pc_r <= 32'd0;
      end
    end
  end

  // Saturating statistics counters and sticky protocol error
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      n_br_r  <= {CNT_W{1'b0}};
      n_mis_r <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if (resolve_s && (n_br_r != STAT_MAX)) begin
        n_br_r <= n_br_r + STAT_ONE;
      end else begin
        n_br_r <= n_br_r;
      end
      if (mispredict_s && (n_mis_r != STAT_MAX)) begin
        n_mis_r <= n_mis_r + STAT_ONE;
      end else begin
        n_mis_r <= n_mis_r;
      end
      err_r <= err_r | err_set_s;
    end
  end

  assign bus.full        = full_s;
  assign bus.upd_br      = upd_br_r;
  assign bus.upd_taken   = upd_taken_r;
  assign bus.upd_correct = upd_correct_r;
  assign bus.upd_target  = upd_target_r;
  assign bus.upd_index   = upd_index_r;
  assign bus.redirect    = redirect_r;
  assign bus.redirect_pc = redirect_pc_r;
  assign bus.err         = err_r;
  assign bus.n_br        = n_br_r;
  assign bus.n_mis       = n_mis_r;

endmodule

// File: tb/tb_br_resolve.sv
// ---------------------------------------------------------------------------
// tb_br_resolve
// Self-checking bench for br_resolve (DEPTH=4, IDX_W=2, CNT_W=16).
// A small queue model of the prediction records produces the expected
// training/redirect packets into a scoreboard queue when a resolution is
// driven; each scenario task pops and compares when the DUT presents it.
// ---------------------------------------------------------------------------
module tb_br_resolve;

  logic CLK;
  logic RST;

  br_resolve_if #(.IDX_W(2), .CNT_W(16)) bus ();

  br_resolve #(.DEPTH(4), .IDX_W(2), .CNT_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        taken;
    logic [1:0]  idx;
    logic [31:0] pc;
    logic [31:0] tgt;
  } rec_t;

  typedef struct {
    logic        taken;
    logic        correct;
    logic [1:0]  idx;
    logic [31:0] target;
    logic        redir;
    logic [31:0] rpc;
  } pkt_t;

  rec_t        mq[$];
  pkt_t        exp_q[$];
  logic [15:0] exp_nbr;
  logic [15:0] exp_nmis;
  int          checks;
  int          errors;

  task automatic idle();
    bus.push        = 1'b0;
    bus.push_taken  = 1'b0;
    bus.push_index  = 2'd0;
    bus.push_pc     = 32'd0;
    bus.push_target = 32'd0;
    bus.ex_valid    = 1'b0;
    bus.ex_taken    = 1'b0;
    bus.ex_target   = 32'd0;
    bus.flush       = 1'b0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_rst();
    RST = 1'b1;
    idle();
    mq.delete();
    exp_q.delete();
    exp_nbr  = 16'd0;
    exp_nmis = 16'd0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Drive a push for the current cycle; the model records it only if accepted.
  task automatic drive_push(input logic t, input logic [1:0] i, input logic [31:0] pc,
                            input logic [31:0] tg, input logic accept);
    rec_t r;
    bus.push        = 1'b1;
    bus.push_taken  = t;
    bus.push_index  = i;
    bus.push_pc     = pc;
    bus.push_target = tg;
    r.taken = t; r.idx = i; r.pc = pc; r.tgt = tg;
    if (accept) mq.push_back(r);
  endtask

  // Drive a resolution and push the expected packet onto the scoreboard.
  task automatic drive_resolve(input logic t, input logic [31:0] tg);
    rec_t r;
    pkt_t p;
    bus.ex_valid  = 1'b1;
    bus.ex_taken  = t;
    bus.ex_target = tg;
    r = mq.pop_front();
    p.taken   = t;
    p.correct = (t == r.taken) && (!t || (tg == r.tgt));
    p.idx     = r.idx;
    p.target  = t ? tg : r.tgt;
    p.redir   = !p.correct;
    p.rpc     = t ? tg : (r.pc + 32'd4);
    exp_q.push_back(p);
    if (exp_nbr != 16'hFFFF) exp_nbr = exp_nbr + 16'd1;
    if (!p.correct) begin
      if (exp_nmis != 16'hFFFF) exp_nmis = exp_nmis + 16'd1;
      mq.delete();
    end
  endtask

  task automatic test_reset();
    logic [71:0] a;
    RST = 1'b1;
    idle();
    @(negedge CLK);
    a = {bus.full, bus.upd_br, bus.upd_taken, bus.upd_correct, bus.upd_index, bus.upd_target,
         bus.redirect, bus.redirect_pc, bus.err};
    checks++;
    if (a !== 72'd0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", a);
    end
    checks++;
    if ({bus.n_br, bus.n_mis} !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %h expected 0", {bus.n_br, bus.n_mis});
    end
    checks++;
    if ({dut.count_r, dut.head_r, dut.tail_r} !== 7'd0) begin
      errors++; $display("FAIL reset_queue got %h expected 0", {dut.count_r, dut.head_r, dut.tail_r});
    end
    RST = 1'b0;
    exp_nbr = 16'd0; exp_nmis = 16'd0;
  endtask

  task automatic test_correct_taken();
    pkt_t e;
    logic [37:0] a, x;
    do_rst();
    drive_push(1'b1, 2'd2, 32'h100, 32'h200, 1'b1);
    cyc();
    bus.push = 1'b0;
    drive_resolve(1'b1, 32'h200);
    cyc();
    bus.ex_valid = 1'b0;
    e = exp_q.pop_front();
    a = {bus.upd_br, bus.upd_taken, bus.upd_correct, bus.upd_index, bus.upd_target, bus.redirect};
    x = {1'b1, e.taken, e.correct, e.idx, e.target, e.redir};
    checks++;
    if (a !== x) begin errors++; $display("FAIL correct_pkt got %h expected %h", a, x); end
    checks++;
    if ({bus.n_br, bus.n_mis} !== {exp_nbr, exp_nmis}) begin
      errors++; $display("FAIL correct_cnt got %h expected %h", {bus.n_br, bus.n_mis}, {exp_nbr, exp_nmis});
    end
    cyc();
    checks++;
    if (bus.upd_br !== 1'b0) begin errors++; $display("FAIL correct_pulse got %b expected 0", bus.upd_br); end
  endtask

  task automatic test_mispredict(input logic pt, input logic [31:0] pc, input logic [31:0] ptg,
                                 input logic et, input logic [31:0] etg, input logic [31:0] want_pc);
    pkt_t e;
    logic [37:0] a, x;
    do_rst();
    drive_push(pt, 2'd1, pc, ptg, 1'b1);
    cyc();
    bus.push = 1'b0;
    drive_resolve(et, etg);
    drive_push(1'b0, 2'd3, 32'hBAD0, 32'hBAD4, 1'b0);   // wrong-path, same cycle
    cyc();
    bus.ex_valid = 1'b0;                                 // push held: wrong-path in redirect cycle
    e = exp_q.pop_front();
    a = {bus.upd_br, bus.upd_taken, bus.upd_correct, bus.upd_index, bus.upd_target, bus.redirect};
    x = {1'b1, e.taken, e.correct, e.idx, e.target, e.redir};
    checks++;
    if (a !== x) begin errors++; $display("FAIL mis_pkt got %h expected %h", a, x); end
    checks++;
    if (bus.redirect_pc !== want_pc || e.rpc !== want_pc) begin
      errors++; $display("FAIL mis_redirect_pc got %h expected %h", bus.redirect_pc, want_pc);
    end
    checks++;
    if ({bus.n_br, bus.n_mis} !== {exp_nbr, exp_nmis}) begin
      errors++; $display("FAIL mis_cnt got %h expected %h", {bus.n_br, bus.n_mis}, {exp_nbr, exp_nmis});
    end
    cyc();
    bus.push = 1'b0;
    checks++;
    if ({dut.count_r, bus.err, bus.redirect} !== 5'd0) begin
      errors++; $display("FAIL mis_cleared got %h expected 0", {dut.count_r, bus.err, bus.redirect});
    end
  endtask

  task automatic test_full();
    pkt_t e;
    logic [37:0] a, x;
    logic [31:0] k;
    do_rst();
    for (int i = 0; i < 4; i++) begin
      k = i;
      drive_push(1'b1, k[1:0], 32'h1000 + 16 * k, 32'h2000 + 16 * k, 1'b1);
      cyc();
    end
    bus.push = 1'b0;
    checks++;
    if ({bus.full, bus.err} !== 2'b10) begin
      errors++; $display("FAIL full_set got %b expected 10", {bus.full, bus.err});
    end
    drive_push(1'b0, 2'd0, 32'hDEAD, 32'hBEEF, 1'b0);
    cyc();
    bus.push = 1'b0;
    checks++;
    if ({bus.err, dut.count_r} !== 4'b1100) begin
      errors++; $display("FAIL full_overflow got %b expected 1100", {bus.err, dut.count_r});
    end
    for (int i = 0; i < 4; i++) begin
      drive_resolve(1'b1, mq[0].tgt);
      cyc();
      e = exp_q.pop_front();
      a = {bus.upd_br, bus.upd_taken, bus.upd_correct, bus.upd_index, bus.upd_target, bus.redirect};
      x = {1'b1, e.taken, e.correct, e.idx, e.target, e.redir};
      checks++;
      if (a !== x) begin errors++; $display("FAIL full_drain%0d got %h expected %h", i, a, x); end
      if (i == 0) begin
        checks++;
        if (bus.full !== 1'b0) begin errors++; $display("FAIL full_clear got %b expected 0", bus.full); end
      end
    end
    bus.ex_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    pkt_t e;
    logic [37:0] a, x;
    logic [31:0] k;
    logic [31:0] etg;
    do_rst();
    for (int i = 0; i < 2; i++) begin
      k = i;
      drive_push(k[0], k[1:0], 32'h300 + 4 * k, 32'h700 + 8 * k, 1'b1);
      cyc();
    end
    for (int i = 2; i < 10; i++) begin
      k = i;
      etg = mq[0].taken ? mq[0].tgt : 32'hD000 + k;
      drive_resolve(mq[0].taken, etg);
      if (i < 8) drive_push(k[0], k[1:0], 32'h300 + 4 * k, 32'h700 + 8 * k, 1'b1);
      else bus.push = 1'b0;
      cyc();
      e = exp_q.pop_front();
      a = {bus.upd_br, bus.upd_taken, bus.upd_correct, bus.upd_index, bus.upd_target, bus.redirect};
      x = {1'b1, e.taken, e.correct, e.idx, e.target, e.redir};
      checks++;
      if (a !== x) begin errors++; $display("FAIL b2b_pkt%0d got %h expected %h", i, a, x); end
      checks++;
      if (dut.count_r !== 3'(mq.size())) begin
        errors++; $display("FAIL b2b_count%0d got %0d expected %0d", i, dut.count_r, mq.size());
      end
    end
    bus.ex_valid = 1'b0;
    bus.push = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] k;
    do_rst();
    for (int i = 0; i < 3; i++) begin
      k = i;
      drive_push(1'b1, k[1:0], 32'h500 + 4 * k, 32'h900, 1'b1);
      cyc();
    end
    drive_push(1'b1, 2'd3, 32'h50C, 32'h900, 1'b0);
    bus.flush = 1'b1;
    cyc();
    bus.push = 1'b0;
    bus.flush = 1'b0;
    mq.delete();
    checks++;
    if ({dut.count_r, bus.full, bus.upd_br, bus.err} !== 6'd0) begin
      errors++; $display("FAIL flush_empty got %b expected 0", {dut.count_r, bus.full, bus.upd_br, bus.err});
    end
    bus.ex_valid = 1'b1; bus.ex_taken = 1'b1; bus.ex_target = 32'h900;
    cyc();
    bus.ex_valid = 1'b0;
    checks++;
    if ({bus.err, bus.upd_br, bus.n_br} !== {1'b1, 1'b0, 16'd0}) begin
      errors++; $display("FAIL flush_ex_err got %h expected %h", {bus.err, bus.upd_br, bus.n_br}, {1'b1, 1'b0, 16'd0});
    end
  endtask

  task automatic test_saturate();
    do_rst();
    force dut.n_mis_r = 16'hFFFF;
    #1;
    release dut.n_mis_r;
    @(negedge CLK);
    exp_nmis = 16'hFFFF;
    drive_push(1'b0, 2'd0, 32'h10, 32'h14, 1'b1);
    cyc();
    bus.push = 1'b0;
    drive_resolve(1'b1, 32'h30);
    cyc();
    bus.ex_valid = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if ({bus.n_br, bus.n_mis, bus.redirect} !== {exp_nbr, exp_nmis, 1'b1}) begin
      errors++; $display("FAIL sat_nmis got %h expected %h", {bus.n_br, bus.n_mis, bus.redirect}, {exp_nbr, exp_nmis, 1'b1});
    end
  endtask

  task automatic test_async_reset();
    logic [71:0] a;
    logic [31:0] k;
    do_rst();
    for (int i = 0; i < 5; i++) begin
      k = i;
      drive_push(1'b1, k[1:0], 32'h600 + 4 * k, 32'hA00, i < 4);
      cyc();
    end
    bus.push = 1'b0;
    drive_resolve(1'b0, 32'h0);
    cyc();
    bus.ex_valid = 1'b0;
    #1;
    RST = 1'b1;
    #1;
    a = {bus.full, bus.upd_br, bus.upd_taken, bus.upd_correct, bus.upd_index, bus.upd_target,
         bus.redirect, bus.redirect_pc, bus.err};
    checks++;
    if (a !== 72'd0) begin errors++; $display("FAIL async_rst_outputs got %h expected 0", a); end
    checks++;
    if ({bus.n_br, bus.n_mis, dut.count_r} !== 35'd0) begin
      errors++; $display("FAIL async_rst_state got %h expected 0", {bus.n_br, bus.n_mis, dut.count_r});
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_correct_taken();
    test_mispredict(1'b0, 32'h40, 32'h1234, 1'b1, 32'h80, 32'h80);
    test_mispredict(1'b1, 32'h3C, 32'h500, 1'b0, 32'h999, 32'h40);
    test_full();
    test_back_to_back();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
